// File: rtl/reg_file_cc.sv
// LC-3 register file R0..R7 with NZP condition codes and branch-enable flag.
// Optional write-through forwarding on the read ports: define REGFILE_BYPASS_EN.
module reg_file_cc #(
  parameter int          DATA_W    = 16,
  parameter int          NREGS     = 8,
  parameter int          ADDR_W    = 3,
  parameter logic [2:0]  RESET_NZP = 3'b010
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              LD_REG,
  input  logic [ADDR_W-1:0] DR,
  input  logic [ADDR_W-1:0] SR1,
  input  logic [ADDR_W-1:0] SR2,
  input  logic [DATA_W-1:0] BUS,
  input  logic              LD_CC,
  input  logic              LD_BEN,
  input  logic [2:0]        IR_NZP,
  input  logic [ADDR_W-1:0] DBG_SEL,
  output logic [DATA_W-1:0] SR1OUT,
  output logic [DATA_W-1:0] SR2OUT,
  output logic [DATA_W-1:0] DBG_OUT,
  output logic [2:0]        NZP,
  output logic              BEN
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  wr_en;
  logic [2:0]        nzp_q, nzp_d;
  logic              ben_q, ben_d;

  // One-hot write decode of the destination index.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_dec
      assign wr_en[gi] = LD_REG && (DR == ADDR_W'(gi));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = wr_en[i] ? BUS : regs_q[i];
    end
  end

  always_comb begin
    nzp_d = nzp_q;
    if (LD_CC) begin
      if (BUS[DATA_W-1])      nzp_d = 3'b100;
      else if (BUS == '0)     nzp_d = 3'b010;
      else                    nzp_d = 3'b001;
    end
  end

  // BEN deliberately evaluates against the pre-edge NZP, even when LD_CC fires too.
  always_comb begin
    ben_d = ben_q;
    if (LD_BEN) ben_d = |(IR_NZP & nzp_q);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      nzp_q <= RESET_NZP;
      ben_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      nzp_q <= nzp_d;
      ben_q <= ben_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = LD_REG && Reset_n;

  always_comb begin
    SR1OUT  = (fwd_ok && SR1 == DR)     ? BUS : regs_q[SR1];
    SR2OUT  = (fwd_ok && SR2 == DR)     ? BUS : regs_q[SR2];
    DBG_OUT = (fwd_ok && DBG_SEL == DR) ? BUS : regs_q[DBG_SEL];
  end
`else
  always_comb begin
    SR1OUT  = regs_q[SR1];
    SR2OUT  = regs_q[SR2];
    DBG_OUT = regs_q[DBG_SEL];
  end
`endif

  assign NZP = nzp_q;
  assign BEN = ben_q;

endmodule

// File: tb/tb_reg_file_cc.sv
// Randomized and directed bench for reg_file_cc against an array-based reference model.
module tb_reg_file_cc;

  logic        Clk = 1'b0;
  logic        Reset_n, LD_REG, LD_CC, LD_BEN;
  logic [2:0]  DR, SR1, SR2, DBG_SEL, IR_NZP;
  logic [15:0] BUS;
  logic [15:0] SR1OUT, SR2OUT, DBG_OUT;
  logic [2:0]  NZP;
  logic        BEN;

  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;
  logic        m_ben;
  int          checks = 0;
  int          errors = 0;

  always #5 Clk = ~Clk;

  reg_file_cc dut (
    .Clk(Clk), .Reset_n(Reset_n), .LD_REG(LD_REG), .DR(DR), .SR1(SR1), .SR2(SR2),
    .BUS(BUS), .LD_CC(LD_CC), .LD_BEN(LD_BEN), .IR_NZP(IR_NZP), .DBG_SEL(DBG_SEL),
    .SR1OUT(SR1OUT), .SR2OUT(SR2OUT), .DBG_OUT(DBG_OUT), .NZP(NZP), .BEN(BEN)
  );

  // Value a read port should show right now given the model and current inputs.
  function automatic logic [15:0] exp_read(input logic [2:0] idx);
`ifdef REGFILE_BYPASS_EN
    if (LD_REG && Reset_n && idx == DR) return BUS;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0)     return 3'b010;
    return 3'b001;
  endfunction

  // Advance one clock and apply the architectural update rules to the model.
  task automatic tick();
    @(posedge Clk);
    if (!Reset_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      m_nzp = 3'b010;
      m_ben = 1'b0;
    end else begin
      if (LD_BEN) m_ben = (IR_NZP & m_nzp) != 3'b000;
      if (LD_REG) m_regs[DR] = BUS;
      if (LD_CC)  m_nzp = cc_of(BUS);
    end
    #1;
  endtask

  task automatic idle();
    Reset_n = 1'b1; LD_REG = 1'b0; LD_CC = 1'b0; LD_BEN = 1'b0;
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
    idle(); LD_REG = 1'b1; DR = idx; BUS = val;
    tick();
    idle();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; LD_REG = 1'b1; DR = 3'd4; BUS = 16'hFFFF;
    LD_CC = 1'b1; LD_BEN = 1'b1; IR_NZP = 3'b111;
    SR1 = 3'd4; SR2 = 3'd0; DBG_SEL = 3'd0;
    tick(); tick();
    #1;
    checks++;
    if (SR1OUT !== 16'h0000) begin
      errors++; $display("FAIL reset_sr1_gated got %h want 0000", SR1OUT);
    end
    for (int i = 0; i < 8; i++) begin
      DBG_SEL = 3'(i); SR2 = 3'(i);
      #1;
      checks++;
      if (DBG_OUT !== 16'h0000 || SR2OUT !== 16'h0000) begin
        errors++; $display("FAIL reset_reg%0d got dbg=%h sr2=%h want 0000", i, DBG_OUT, SR2OUT);
      end
    end
    checks++;
    if (NZP !== 3'b010 || BEN !== 1'b0) begin
      errors++; $display("FAIL reset_cc got nzp=%b ben=%b want 010/0", NZP, BEN);
    end
    idle();
    $display("reset: nzp=%b ben=%b", NZP, BEN);
  endtask

  task automatic test_write_read();
    write_reg(3'd3, 16'h1234);
    write_reg(3'd5, 16'hABCD);
    SR1 = 3'd3; SR2 = 3'd5; DBG_SEL = 3'd3;
    #1;
    checks++;
    if (SR1OUT !== 16'h1234 || SR2OUT !== 16'hABCD || DBG_OUT !== 16'h1234) begin
      errors++;
      $display("FAIL write_read got sr1=%h sr2=%h dbg=%h want 1234/abcd/1234", SR1OUT, SR2OUT, DBG_OUT);
    end
    $display("write_read: sr1=%h sr2=%h dbg=%h", SR1OUT, SR2OUT, DBG_OUT);
  endtask

  task automatic test_hazard();
    logic [15:0] want;
    write_reg(3'd2, 16'h0001);
    LD_REG = 1'b1; DR = 3'd2; SR2 = 3'd2; BUS = 16'h00FF;
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 16'h00FF;
`else
    want = 16'h0001;
`endif
    checks++;
    if (SR2OUT !== want) begin
      errors++; $display("FAIL hazard_same_cycle got %h want %h", SR2OUT, want);
    end
    tick();
    idle();
    #1;
    checks++;
    if (SR2OUT !== 16'h00FF) begin
      errors++; $display("FAIL hazard_next_cycle got %h want 00ff", SR2OUT);
    end
    $display("hazard: sr2 after write=%h", SR2OUT);
  endtask

  task automatic test_cc();
    logic [15:0] vals [3] = '{16'h8000, 16'h0000, 16'h7FFF};
    logic [2:0]  want [3] = '{3'b100, 3'b010, 3'b001};
    for (int i = 0; i < 3; i++) begin
      idle(); LD_CC = 1'b1; BUS = vals[i];
      tick();
      idle();
      checks++;
      if (NZP !== want[i]) begin
        errors++; $display("FAIL cc_bus_%h got %b want %b", vals[i], NZP, want[i]);
      end
      $display("cc: bus=%h nzp=%b", vals[i], NZP);
    end
  endtask

  task automatic test_ben();
    idle(); LD_CC = 1'b1; BUS = 16'h0001; tick();
    idle(); LD_BEN = 1'b1; IR_NZP = 3'b001; tick(); idle();
    checks++;
    if (BEN !== 1'b1) begin
      errors++; $display("FAIL ben_match got %b want 1", BEN);
    end
    LD_BEN = 1'b1; IR_NZP = 3'b110; tick(); idle();
    checks++;
    if (BEN !== 1'b0) begin
      errors++; $display("FAIL ben_nomatch got %b want 0", BEN);
    end
    LD_CC = 1'b1; BUS = 16'h0000; LD_BEN = 1'b1; IR_NZP = 3'b010; tick(); idle();
    checks++;
    if (BEN !== 1'b0 || NZP !== 3'b010) begin
      errors++; $display("FAIL ben_old_nzp_a got ben=%b nzp=%b want 0/010", BEN, NZP);
    end
    LD_CC = 1'b1; BUS = 16'h0042; LD_BEN = 1'b1; IR_NZP = 3'b010; tick(); idle();
    checks++;
    if (BEN !== 1'b1 || NZP !== 3'b001) begin
      errors++; $display("FAIL ben_old_nzp_b got ben=%b nzp=%b want 1/001", BEN, NZP);
    end
    $display("ben: ben=%b nzp=%b", BEN, NZP);
  endtask

  task automatic test_reset_midop();
    write_reg(3'd7, 16'h5A5A);
    LD_CC = 1'b1; BUS = 16'hF000; tick(); idle();
    Reset_n = 1'b0; LD_REG = 1'b1; DR = 3'd7; BUS = 16'hBEEF; LD_CC = 1'b1;
    tick();
    idle();
    DBG_SEL = 3'd7;
    #1;
    checks++;
    if (DBG_OUT !== 16'h0000 || NZP !== 3'b010) begin
      errors++; $display("FAIL reset_midop got r7=%h nzp=%b want 0000/010", DBG_OUT, NZP);
    end
    $display("reset_midop: r7=%h nzp=%b", DBG_OUT, NZP);
  endtask

  task automatic test_random();
    int bad;
    for (int n = 0; n < 400; n++) begin
      Reset_n = ($urandom_range(0, 39) != 0);
      LD_REG  = $urandom_range(0, 1) == 1;
      LD_CC   = $urandom_range(0, 2) == 0;
      LD_BEN  = $urandom_range(0, 2) == 0;
      DR      = 3'($urandom_range(0, 7));
      SR1     = ($urandom_range(0, 3) == 0) ? DR : 3'($urandom_range(0, 7));
      SR2     = ($urandom_range(0, 3) == 0) ? DR : 3'($urandom_range(0, 7));
      DBG_SEL = 3'($urandom_range(0, 7));
      IR_NZP  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       BUS = 16'h0000;
        1:       BUS = {1'b1, 15'($urandom)};
        default: BUS = 16'($urandom);
      endcase
      #1;
      bad = 0;
      checks++;
      if (SR1OUT !== exp_read(SR1) || SR2OUT !== exp_read(SR2) || DBG_OUT !== exp_read(DBG_SEL)) bad = 1;
      if (NZP !== m_nzp || BEN !== m_ben) bad = 1;
      if (bad != 0) begin
        errors++;
        $display("FAIL random_%0d got sr1=%h sr2=%h dbg=%h nzp=%b ben=%b want %h/%h/%h/%b/%b",
                 n, SR1OUT, SR2OUT, DBG_OUT, NZP, BEN,
                 exp_read(SR1), exp_read(SR2), exp_read(DBG_SEL), m_nzp, m_ben);
      end
      tick();
    end
    idle();
    $display("random: 400 cycles done, errors so far %0d", errors);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_nzp = 3'b010; m_ben = 1'b0;
    idle(); DR = 3'd0; SR1 = 3'd0; SR2 = 3'd0; DBG_SEL = 3'd0; IR_NZP = 3'd0; BUS = 16'h0;
    @(negedge Clk);
    test_reset();
    test_write_read();
    test_hazard();
    test_cc();
    test_ben();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
